// File: rtl/kband_pkg.sv
// Shared KBand constants and the skid-buffer occupancy type.
package kband_pkg;

    localparam int KBAND_ROW_W     = 4096;
    localparam int KBAND_BEAT_W    = 128;
    localparam int KBAND_PKT_BEATS = KBAND_ROW_W / KBAND_BEAT_W;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_count(input occ_e occ);
        case (occ)
            OCC_ONE: occ_count = 2'd1;
            OCC_TWO: occ_count = 2'd2;
            default: occ_count = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/kband_skid_buf.sv
// Two-entry FIFO-ordered holding buffer; entry 0 is always the head.
module kband_skid_buf
    import kband_pkg::*;
#(
    parameter int DATA_W = KBAND_BEAT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output occ_e              occ_o
);

    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] mem0_q, mem0_d;
    logic [DATA_W-1:0] mem1_q, mem1_d;

    // Push into TWO without a pop cannot happen: the upstream credit check prevents it.
    always_comb begin
        occ_d  = occ_q;
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push_i) begin
                    mem0_d = din_i;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                case ({push_i, pop_i})
                    2'b11: mem0_d = din_i;
                    2'b10: begin
                        mem1_d = din_i;
                        occ_d  = OCC_TWO;
                    end
                    2'b01: occ_d = OCC_EMPTY;
                    default: ;
                endcase
            end
            OCC_TWO: begin
                if (pop_i) begin
                    mem0_d = mem1_q;
                    if (push_i) mem1_d = din_i;
                    else        occ_d  = OCC_ONE;
                end
            end
            default: occ_d = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q  <= OCC_EMPTY;
            mem0_q <= '0;
            mem1_q <= '0;
        end else begin
            occ_q  <= occ_d;
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
        end
    end

    assign dout_o = mem0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/kband_out_streamer.sv
// Drains the KBand output FIFO into an Avalon-ST source with SOP/EOP framing.
module kband_out_streamer
    import kband_pkg::*;
#(
    parameter int DATA_W    = KBAND_BEAT_W,
    parameter int PKT_BEATS = KBAND_PKT_BEATS,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] fifo_q,
    input  logic              fifo_rdempty,
    output logic              fifo_rdreq,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic              src_sop,
    output logic              src_eop,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              busy
);

    localparam logic [15:0] LAST_IDX = 16'(PKT_BEATS - 1);

    occ_e             occ;
    logic             inflight_q;
    logic [15:0]      beat_idx_q, beat_idx_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic             handshake;
    logic             last_beat;
    logic [2:0]       credits_used;

    kband_skid_buf #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (inflight_q),
        .pop_i   (handshake),
        .din_i   (fifo_q),
        .dout_o  (src_data),
        .occ_o   (occ)
    );

    // Buffered plus in-flight words may never exceed the two buffer slots.
    assign credits_used = {1'b0, occ_count(occ)} + {2'b00, inflight_q};
    assign fifo_rdreq   = reset_n && enable && !fifo_rdempty && (credits_used < 3'd2);

    assign src_valid = (occ != OCC_EMPTY);
    assign handshake = src_valid && src_ready;
    assign last_beat = (beat_idx_q == LAST_IDX);
    assign src_sop   = src_valid && (beat_idx_q == 16'd0);
    assign src_eop   = src_valid && last_beat;
    assign busy      = inflight_q || (occ != OCC_EMPTY);
    assign pkt_count = pkt_count_q;

    always_comb begin
        beat_idx_d  = beat_idx_q;
        pkt_count_d = pkt_count_q;
        if (handshake) begin
            if (last_beat) begin
                beat_idx_d  = 16'd0;
                pkt_count_d = pkt_count_q + 1'b1;
            end else begin
                beat_idx_d  = beat_idx_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q  <= 1'b0;
            beat_idx_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            inflight_q  <= fifo_rdreq;
            beat_idx_q  <= beat_idx_d;
            pkt_count_q <= pkt_count_d;
        end
    end

endmodule

// File: tb/tb_kband_out_streamer.sv
// Self-checking bench: FIFO model, randomized ready/data, word-level reference model.
module tb_kband_out_streamer;

    localparam int DATA_W = 128;
    localparam int PKT    = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdempty;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_sop;
    logic              src_eop;
    logic [CNT_W-1:0]  pkt_count;
    logic              busy;

    kband_out_streamer #(.DATA_W(DATA_W), .PKT_BEATS(PKT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .fifo_q       (fifo_q),
        .fifo_rdempty (fifo_rdempty),
        .fifo_rdreq   (fifo_rdreq),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_ready    (src_ready),
        .src_sop      (src_sop),
        .src_eop      (src_eop),
        .pkt_count    (pkt_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Normal-mode FIFO: data appears the cycle after rdreq; aclr tied to reset.
    logic [DATA_W-1:0] fifoMem [0:1023];
    int wrPtr = 0;
    int rdPtr;
    assign fifo_rdempty = (wrPtr == rdPtr);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdPtr  <= wrPtr;
            fifo_q <= '0;
        end else if (fifo_rdreq) begin
            fifo_q <= fifoMem[rdPtr[9:0]];
            rdPtr  <= rdPtr + 1;
        end
    end

    logic [DATA_W-1:0] expQ [$];
    int errors = 0;
    int checks = 0;
    int expBeat, expPkts, issued, accepted, cycleNum;
    int firstRd, firstVal;
    bit prevRdreq, prevStall;
    logic [DATA_W-1:0] prevData;
    logic prevValid, prevSop, prevEop;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("[TB] FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic pushWord(input logic [DATA_W-1:0] w);
        fifoMem[wrPtr[9:0]] = w;
        wrPtr++;
        expQ.push_back(w);
    endtask

    function automatic logic [DATA_W-1:0] randWord();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic clearModel();
        expQ.delete();
        expBeat   = 0;
        expPkts   = 0;
        issued    = 0;
        accepted  = 0;
        prevRdreq = 0;
        prevStall = 0;
    endtask

    // Drive one cycle's inputs at the falling edge, then check against the model.
    task automatic applyStimulus(input bit rdy, input bit en);
        int level;
        src_ready = rdy;
        enable    = en;
        #1;
        level = issued - accepted;
        checkOutput("rdreq", fifo_rdreq, en && !fifo_rdempty && level < 2);
        checkOutput("underflow", fifo_rdreq && fifo_rdempty, 1'b0);
        checkOutput("valid", src_valid, (level - int'(prevRdreq)) > 0);
        checkOutput("busy", busy, level > 0);
        checkOutput("pkt_count", pkt_count, expPkts);
        if (prevStall) begin
            checkOutput("stall_data", src_data, prevData);
            checkOutput("stall_valid", src_valid, prevValid);
            checkOutput("stall_sop", src_sop, prevSop);
            checkOutput("stall_eop", src_eop, prevEop);
        end
        if (src_valid) begin
            checkOutput("sop", src_sop, expBeat == 0);
            checkOutput("eop", src_eop, expBeat == PKT - 1);
            if (firstVal < 0) firstVal = cycleNum;
        end
        if (src_valid && rdy) begin
            if (expQ.size() > 0) begin
                checkOutput("data", src_data, expQ[0]);
                expQ.pop_front();
            end else begin
                checkOutput("extra_beat", 1'b1, 1'b0);
            end
            accepted++;
            if (expBeat == PKT - 1) begin
                expBeat = 0;
                expPkts++;
            end else begin
                expBeat++;
            end
        end
        if (fifo_rdreq) begin
            issued++;
            if (firstRd < 0) firstRd = cycleNum;
        end
        prevRdreq = fifo_rdreq;
        prevStall = src_valid && !rdy;
        prevData  = src_data;
        prevValid = src_valid;
        prevSop   = src_sop;
        prevEop   = src_eop;
        cycleNum++;
        @(negedge clk);
    endtask

    // mode 0: ready held high, 1: pattern 1,0,0,1, 2: random ready.
    task automatic runUntil(input int target, input int mode, input int budget);
        int n = 0;
        bit rdy;
        while (accepted < target && n < budget) begin
            case (mode)
                1:       rdy = (cycleNum % 4 == 0) || (cycleNum % 4 == 3);
                2:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = 1'b1;
            endcase
            applyStimulus(rdy, 1'b1);
            n++;
        end
        checkOutput("reach_target", accepted >= target, 1'b1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_rdreq", fifo_rdreq, 1'b0);
        checkOutput("rst_valid", src_valid, 1'b0);
        checkOutput("rst_sop", src_sop, 1'b0);
        checkOutput("rst_eop", src_eop, 1'b0);
        checkOutput("rst_data", src_data, '0);
        checkOutput("rst_pkt_count", pkt_count, '0);
        checkOutput("rst_busy", busy, 1'b0);
    endtask

    task automatic pulseReset();
        reset_n = 1'b0;
        #1;
        checkResetOutputs();
        clearModel();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int n;
        reset_n   = 1'b1;
        enable    = 1'b1;
        src_ready = 1'b0;
        cycleNum  = 0;
        firstRd   = -1;
        firstVal  = -1;
        @(negedge clk);
        pulseReset();

        $display("[TB] single packet, words 0..31");
        for (int i = 0; i < 32; i++) pushWord(DATA_W'(i));
        runUntil(32, 0, 200);
        checkOutput("first_latency", firstVal - firstRd, 2);
        checkOutput("pkt_after_1", pkt_count, 1);

        $display("[TB] ready toggling 1,0,0,1");
        for (int i = 0; i < 32; i++) pushWord(randWord());
        runUntil(64, 1, 400);
        checkOutput("pkt_after_2", pkt_count, 2);

        $display("[TB] FIFO runs dry after 3 words");
        for (int i = 0; i < 3; i++) pushWord(randWord());
        runUntil(67, 0, 50);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("dry_valid", src_valid, 1'b0);
        checkOutput("dry_rdreq", fifo_rdreq, 1'b0);
        for (int i = 0; i < 29; i++) pushWord(randWord());
        runUntil(96, 2, 400);
        checkOutput("pkt_after_3", pkt_count, 3);

        $display("[TB] enable dropped at beat 10");
        for (int i = 0; i < 32; i++) pushWord(randWord());
        runUntil(106, 0, 100);
        n = 0;
        while (busy && n < 20) begin
            applyStimulus(1'b1, 1'b0);
            n++;
        end
        checkOutput("disable_busy", busy, 1'b0);
        checkOutput("disable_extra_beats", (accepted - 106) <= 2, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("disable_no_read", accepted <= 108, 1'b1);
        runUntil(128, 0, 200);
        checkOutput("pkt_after_4", pkt_count, 4);

        $display("[TB] two packets back-to-back, random ready");
        for (int i = 0; i < 64; i++) pushWord(randWord());
        runUntil(192, 2, 800);
        checkOutput("pkt_after_6", pkt_count, 6);

        $display("[TB] reset at beat 17");
        for (int i = 0; i < 32; i++) pushWord(randWord());
        runUntil(209, 0, 200);
        pulseReset();
        checkOutput("post_rst_pkt", pkt_count, 0);
        for (int i = 0; i < 32; i++) pushWord(randWord());
        runUntil(32, 0, 200);
        checkOutput("pkt_after_reset", pkt_count, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
